// File: rtl/prio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prio_arbiter_pkg
// Shared types and constants for the priority arbiter.
//   state_e : arbiter FSM states (IDLE, GRANT)
//   HOLD_W  : width of the hold_cnt output, which counts cycles a grant is held
// -----------------------------------------------------------------------------
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int HOLD_W = 8;

endpackage : prio_arbiter_pkg

// File: rtl/prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Purely combinational rotated priority search. It starts at i_start and walks
// downward, wrapping from index 0 to N-1. It reports the first set bit of
// i_vec.
// Ports:
//   i_vec   [N-1:0] : candidate vector
//   i_start [W-1:0] : first index examined (highest priority this cycle)
//   o_found         : 1 when i_vec has any bit set
//   o_idx   [W-1:0] : index of the winning bit (0 when nothing is found)
// -----------------------------------------------------------------------------
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_pos;

  // Search order is i_start, i_start-1, ..., 0, N-1, ... .
  // The first hit wins, so later positions are ignored once o_found is set.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = i_start;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_vec[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
      w_pos = (w_pos == '0) ? W'(N - 1) : w_pos - W'(1);
    end
  end

endmodule : prio_pick

// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
// A two-state (IDLE/GRANT) arbiter with registered outputs.
// In IDLE, any request wins a grant on the next edge. A grant lasts until the
// owner raises done, or until it has been held MAX_HOLD cycles. When the hold
// limit ends a grant, preempt pulses for one cycle.
// Build option: define PRIO_ARBITER_ROUND_ROBIN_EN to replace fixed priority
// with a rotating pointer. The pointer moves to just below the last winner.
// Without the macro, index N-1 always has the highest priority.
// Ports:
//   clk, rst (async, active-high)
//   req        [N-1:0] : request vector
//   done               : owner releases the grant (only looked at in GRANT)
//   gnt_valid          : a grant is held
//   gnt_idx    [W-1:0] : granted index (keeps its last value while idle)
//   gnt_onehot [N-1:0] : one-hot grant, zero while idle
//   preempt            : one-cycle pulse when the hold limit ends a grant
//   hold_cnt   [7:0]   : cycles the current grant has been held
// -----------------------------------------------------------------------------
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int W        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic              done,
  output logic              gnt_valid,
  output logic [W-1:0]      gnt_idx,
  output logic [N-1:0]      gnt_onehot,
  output logic              preempt,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [W-1:0]      TOP_IDX  = W'(N - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_e              r_state, w_state_next;
  logic                r_gnt_valid, w_gnt_valid_next;
  logic [W-1:0]        r_gnt_idx, w_gnt_idx_next;
  logic [N-1:0]        r_gnt_onehot, w_gnt_onehot_next;
  logic                r_preempt, w_preempt_next;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_next;

  logic                w_found;
  logic [W-1:0]        w_pick_idx;
  logic [W-1:0]        w_start;
  logic                w_hold_hit;

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
  logic [W-1:0]        r_ptr, w_ptr_next;
  assign w_start = r_ptr;
`else
  assign w_start = TOP_IDX;
`endif

  prio_pick #(.N(N)) u_pick (
    .i_vec   (req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_hold_hit = (r_hold_cnt == HOLD_LIM);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_preempt    <= 1'b0;
      r_hold_cnt   <= '0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
      r_ptr        <= TOP_IDX;
`endif
    end else begin
      r_state      <= w_state_next;
      r_gnt_valid  <= w_gnt_valid_next;
      r_gnt_idx    <= w_gnt_idx_next;
      r_gnt_onehot <= w_gnt_onehot_next;
      r_preempt    <= w_preempt_next;
      r_hold_cnt   <= w_hold_cnt_next;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
      r_ptr        <= w_ptr_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_next = GRANT;
      GRANT:   if (done || w_hold_hit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  // done is checked before the hold limit, so a release on the limit cycle
  // never raises preempt.
  always_comb begin
    w_gnt_valid_next  = 1'b0;
    w_gnt_idx_next    = r_gnt_idx;
    w_gnt_onehot_next = '0;
    w_preempt_next    = 1'b0;
    w_hold_cnt_next   = '0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
    w_ptr_next        = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_valid_next  = 1'b1;
          w_gnt_idx_next    = w_pick_idx;
          w_gnt_onehot_next = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
          w_hold_cnt_next   = HOLD_W'(1);
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
          w_ptr_next        = (w_pick_idx == '0) ? TOP_IDX : w_pick_idx - W'(1);
`endif
        end
      end
      GRANT: begin
        if (done) begin
          w_preempt_next = 1'b0;
        end else if (w_hold_hit) begin
          w_preempt_next = 1'b1;
        end else begin
          w_gnt_valid_next  = 1'b1;
          w_gnt_onehot_next = r_gnt_onehot;
          w_hold_cnt_next   = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = r_gnt_onehot;
  assign preempt    = r_preempt;
  assign hold_cnt   = r_hold_cnt;

endmodule : prio_arbiter

// File: tb/tb_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter
// Directed bench for prio_arbiter with N=4 and MAX_HOLD=4.
// The fixed-priority or round-robin expectations are chosen by
// PRIO_ARBITER_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_prio_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int W        = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic         preempt;
  logic [7:0]   hold_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
  localparam int NG = 5;
  int seq_all[NG] = '{3, 2, 1, 0, 3};
  int seq_0101[3] = '{2, 0, 2};
`else
  localparam int NG = 3;
  int seq_all[NG] = '{3, 3, 3};
  int seq_0101[3] = '{2, 2, 2};
`endif

  prio_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .preempt    (preempt),
    .hold_cnt   (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    tick(); tick();
    chk("rst_valid",   32'(gnt_valid),  0);
    chk("rst_idx",     32'(gnt_idx),    0);
    chk("rst_onehot",  32'(gnt_onehot), 0);
    chk("rst_preempt", 32'(preempt),    0);
    chk("rst_hold",    32'(hold_cnt),   0);

    // The first arbitration after release uses req 1010, so index 3 wins.
    rst = 1'b0; req = 4'b1010;
    tick();
    chk("g1_valid",  32'(gnt_valid),  1);
    chk("g1_idx",    32'(gnt_idx),    3);
    chk("g1_onehot", 32'(gnt_onehot), 32'b1000);
    chk("g1_hold",   32'(hold_cnt),   1);

    // req drops and the grant is still held. hold_cnt counts 2..4, then preempt.
    req = 4'b0000;
    for (int h = 2; h <= MAX_HOLD; h++) begin
      tick();
      chk("hold_valid",  32'(gnt_valid),  1);
      chk("hold_idx",    32'(gnt_idx),    3);
      chk("hold_onehot", 32'(gnt_onehot), 32'b1000);
      chk("hold_cnt",    32'(hold_cnt),   32'(h));
    end
    tick();
    chk("pre_pulse",  32'(preempt),    1);
    chk("pre_valid",  32'(gnt_valid),  0);
    chk("pre_onehot", 32'(gnt_onehot), 0);
    chk("pre_idx",    32'(gnt_idx),    3);
    chk("pre_hold",   32'(hold_cnt),   0);
    tick();
    chk("pre_once",   32'(preempt),    0);
    chk("idle_valid", 32'(gnt_valid),  0);

    // done on the same cycle hold_cnt hits the limit: done wins, no preempt.
    req = 4'b0100;
    tick();
    chk("g2_idx", 32'(gnt_idx), 2);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("g2_hold4", 32'(hold_cnt), 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("dwin_preempt", 32'(preempt),   0);
    chk("dwin_valid",   32'(gnt_valid), 0);

    // Reset in the middle of a grant must act with no clock edge.
    req = 4'b0100;
    tick();
    chk("g3_idx",   32'(gnt_idx),   2);
    chk("g3_valid", 32'(gnt_valid), 1);
    req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",   32'(gnt_valid),  0);
    chk("arst_onehot",  32'(gnt_onehot), 0);
    chk("arst_idx",     32'(gnt_idx),    0);
    chk("arst_preempt", 32'(preempt),    0);
    tick();
    rst = 1'b0; req = 4'b0001;
    tick();
    chk("post_rst_valid",  32'(gnt_valid),  1);
    chk("post_rst_idx",    32'(gnt_idx),    0);
    chk("post_rst_onehot", 32'(gnt_onehot), 32'b0001);

    // All requesters active. done is pulsed on each grant, so grants are two cycles apart.
    req = 4'b1111; done = 1'b1;
    tick();
    done = 1'b0;
    chk("all_gap0", 32'(gnt_valid), 0);
    tick();
    for (int g = 0; g < NG; g++) begin
      chk("all_valid", 32'(gnt_valid), 1);
      chk("all_idx",   32'(gnt_idx),   32'(seq_all[g]));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("all_gap", 32'(gnt_valid), 0);
      tick();
    end

    // Grant to 0, then alternate on req 0101.
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0001;
    tick();
    chk("p_idx0", 32'(gnt_idx), 0);
    req = 4'b0101;
    for (int g = 0; g < 3; g++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("alt_valid", 32'(gnt_valid), 1);
      chk("alt_idx",   32'(gnt_idx),   32'(seq_0101[g]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_prio_arbiter

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 8: number of requesters, legal range 2..64.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant length in cycles, legal range 1..255.
REQ-003 Derived localparam W = $clog2(N): grant index width.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 req  input  N  request vector; bit i = requester i.
REQ-007 done  input  1  owner releases the grant; sampled only in GRANT.
REQ-008 gnt_valid  output  1  a grant is held.
REQ-009 gnt_idx  output  W  index of the granted requester.
REQ-010 gnt_onehot  output  N  one-hot grant; all zeros when gnt_valid=0.
REQ-011 preempt  output  1  single-cycle pulse when a grant is force-ended by MAX_HOLD.
REQ-012 hold_cnt  output  8  cycles the current grant has been held.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT, and all outputs SHALL be registered.
REQ-014 IDLE: if req != 0, go to GRANT at the next edge; gnt_valid=1 and gnt_idx = winner of req at that edge (latency 1 cycle).
REQ-015 IDLE with req == 0 SHALL stay in IDLE, with gnt_valid=0, gnt_onehot=0 and gnt_idx holding its last value.
REQ-016 GRANT SHALL hold gnt_idx and gnt_onehot constant even if the owner's req drops; only done or the hold limit ends a grant.
REQ-017 GRANT with done=1 SHALL go to IDLE next cycle (gnt_valid=0); the earliest next grant is 2 cycles after done.
REQ-018 hold_cnt SHALL load 1 on entering GRANT, increment each GRANT cycle, and reset to 0 in IDLE.
REQ-019 GRANT with hold_cnt == MAX_HOLD and done=0 SHALL go to IDLE with preempt=1 for exactly that one cycle.
REQ-020 If done=1 and hold_cnt == MAX_HOLD in the same cycle, done SHALL win and preempt SHALL stay 0.
REQ-021 Fixed-priority winner: highest set index; N-1 is highest priority and 0 is lowest.
REQ-022 A winner SHALL exist only when req != 0; no X/Z propagation is permitted on any output.

Reset
REQ-023 With rst=1 the outputs SHALL be immediately, with no clock: state IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, preempt=0, hold_cnt=0, rotation pointer = N-1.
REQ-024 rst asserted during GRANT SHALL drop the grant immediately, and no preempt SHALL be generated.
REQ-025 The first arbitration after reset SHALL use req sampled on the first edge after rst is released.

Configuration
REQ-026 Macro PRIO_ARBITER_ROUND_ROBIN_EN defined: the winner SHALL be the first set bit searching downward from pointer ptr, wrapping from 0 to N-1.
REQ-027 With the macro, on every new grant to index i, ptr SHALL become (i-1) mod N; i=0 wraps to N-1.
REQ-028 Macro undefined: fixed priority per REQ-021, and the pointer logic SHALL NOT be present.

Structure
REQ-029 Package prio_arbiter_pkg SHALL hold the state enum typedef (IDLE, GRANT) and the hold_cnt width constant (8).
REQ-030 Sub-module prio_pick SHALL implement the purely combinational rotated priority search: inputs vector and start pointer; outputs found and index.
REQ-031 In fixed mode, prio_pick SHALL be instantiated with its start pointer tied to N-1.

Verification (N=4, MAX_HOLD=4)
REQ-032 Reset mid-GRANT (gnt_idx=2), then rst=1 -> gnt_valid=0 and gnt_onehot=0000 with no clock edge; after release with req=0001 -> gnt_idx=0 one cycle later.
REQ-033 req=1010 in IDLE -> next cycle gnt_valid=1, gnt_idx=3, gnt_onehot=1000; req dropped to 0000 -> grant still held.
REQ-034 Grant held with done=0 -> hold_cnt 1,2,3,4, then preempt=1 for one cycle, gnt_valid=0; done on the hold_cnt=4 cycle -> preempt=0.
REQ-035 Fixed mode, req=1111 held, done pulsed each grant -> grants 3,3,3 with 2-cycle spacing.
REQ-036 ROUND_ROBIN_EN, req=1111 held, done pulsed each grant -> grants 3,2,1,0,3.
REQ-037 ROUND_ROBIN_EN, req=0101 after a grant to 0 (ptr=3) -> grant 2, then 0, then 2.
